// File: rtl/lane_scroller_if.sv
// Bus between game-state logic (master) and the lane scroller (slave).
// No backpressure: config inputs are level signals, load is a per-lane strobe, and tick/wrapped are one-cycle qualifiers.
interface lane_scroller_if #(
  parameter int NUM_LANES = 4,
  parameter int POS_W     = 10,
  parameter int STEP_W    = 3,
  parameter int SCORE_W   = 8
);
  logic                           enable;
  logic [SCORE_W-1:0]             score;
  logic [NUM_LANES-1:0]           dir;
  logic [NUM_LANES*STEP_W-1:0]    step;
  logic [NUM_LANES-1:0]           load;
  logic [NUM_LANES*POS_W-1:0]     start_pos;
  logic [NUM_LANES*POS_W-1:0]     pos;
  logic                           tick;
  logic [NUM_LANES-1:0]           wrapped;

  modport master (
    output enable, score, dir, step, load, start_pos,
    input  pos, tick, wrapped
  );

  modport slave (
    input  enable, score, dir, step, load, start_pos,
    output pos, tick, wrapped
  );
endinterface

// File: rtl/lane_scroller.sv
// Multi-lane horizontal obstacle scroller: one score-scaled move timer drives
// NUM_LANES modular x-positions with per-lane direction, step and reload.
module lane_scroller #(
  parameter int NUM_LANES    = 4,
  parameter int POS_W        = 10,
  parameter int SCREEN_WIDTH = 640,
  parameter int STEP_W       = 3,
  parameter int CTR_W        = 18,
  parameter int BASE_PERIOD  = 15000,
  parameter int MIN_PERIOD   = 1000,
  parameter int SCORE_W      = 8,
  parameter int SCORE_SHIFT  = 5
) (
  input  logic           clk,
  input  logic           reset,
  lane_scroller_if.slave bus
);
  localparam logic [POS_W:0] SCREEN = (POS_W+1)'(SCREEN_WIDTH);
  localparam logic [CTR_W:0] BASE   = (CTR_W+1)'(BASE_PERIOD);
  localparam logic [CTR_W:0] FLOOR  = (CTR_W+1)'(MIN_PERIOD);

  logic [CTR_W-1:0]                   ctr;
  logic [CTR_W:0]                     score_scaled;
  logic [CTR_W:0]                     period_raw;
  logic [CTR_W-1:0]                   period;
  logic [CTR_W-1:0]                   last_count;
  logic                               fire;
  logic [NUM_LANES-1:0][POS_W-1:0]    pos_q;
  logic [NUM_LANES-1:0][POS_W-1:0]    next_pos;
  logic [NUM_LANES-1:0][POS_W-1:0]    start_clean;
  logic [NUM_LANES-1:0]               next_wrap;
  logic [NUM_LANES-1:0]               wrapped_q;
  logic                               tick_q;

  function automatic logic [POS_W-1:0] sanitise(input logic [POS_W-1:0] v);
    return ({1'b0, v} >= SCREEN) ? '0 : v;
  endfunction

  // The top bit of period_raw flags a negative period; >= lets a mid-count speed-up fire at once.
  always_comb begin
    score_scaled = (CTR_W+1)'(bus.score) << SCORE_SHIFT;
    period_raw   = BASE - score_scaled;
    if (period_raw[CTR_W] || (period_raw < FLOOR)) begin
      period = CTR_W'(MIN_PERIOD);
    end else begin
      period = period_raw[CTR_W-1:0];
    end
    last_count = period - CTR_W'(1);
    fire       = bus.enable && (ctr >= last_count);
  end

  always_comb begin
    logic [POS_W:0] cur;
    logic [POS_W:0] stp;
    logic [POS_W:0] sum;
    next_pos    = pos_q;
    next_wrap   = '0;
    start_clean = '0;
    cur         = '0;
    stp         = '0;
    sum         = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      start_clean[i] = sanitise(bus.start_pos[i*POS_W +: POS_W]);
      cur = {1'b0, pos_q[i]};
      stp = (POS_W+1)'(bus.step[i*STEP_W +: STEP_W]);
      sum = cur + stp;
      // Load wins over a coincident move for its own lane only.
      if (bus.load[i]) begin
        next_pos[i] = start_clean[i];
      end else if (fire) begin
        if (!bus.dir[i]) begin
          if (sum >= SCREEN) begin
            next_pos[i]  = POS_W'(sum - SCREEN);
            next_wrap[i] = 1'b1;
          end else begin
            next_pos[i] = POS_W'(sum);
          end
        end else if (cur < stp) begin
          next_pos[i]  = POS_W'(cur + SCREEN - stp);
          next_wrap[i] = 1'b1;
        end else begin
          next_pos[i] = POS_W'(cur - stp);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr       <= '0;
      tick_q    <= 1'b0;
      wrapped_q <= '0;
      pos_q     <= start_clean;
    end else begin
      tick_q    <= fire;
      wrapped_q <= next_wrap;
      pos_q     <= next_pos;
      if (bus.enable) begin
        ctr <= fire ? '0 : ctr + CTR_W'(1);
      end
    end
  end

  assign bus.pos     = pos_q;
  assign bus.tick    = tick_q;
  assign bus.wrapped = wrapped_q;
endmodule
